// File: rtl/lfsr_scrambler_pkg.sv
// lfsr_scrambler_pkg
//   Definitions shared by the scrambler transmitter and the descrambler
//   receiver: default polynomial/seed, the LFSR next-state function and the
//   receiver frame-state encoding.
package lfsr_scrambler_pkg;

  // x^7 + x^6 + 1, loaded with all ones at frame start
  localparam logic [6:0] DEF_POLY = 7'h60;
  localparam logic [6:0] DEF_SEED = 7'h7F;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  // Left-shift LFSR step; the feedback bit is the XOR of the tapped bits.
  // Operands are zero-extended to 32 bits, so the caller keeps its low
  // LFSR_W bits of the result.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] poly);
    return {state[30:0], ^(state & poly)};
  endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// lfsr_keystream
//   Keystream generator shared by the transmitter and the receiver.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset (lfsr <= SEED)
//     load_i    - treat the LFSR as SEED for the bit being processed
//     adv_i     - a bit is processed this cycle; step the LFSR
//     k_o       - keystream bit for the current bit (MSB of the LFSR)
module lfsr_keystream
  import lfsr_scrambler_pkg::*;
#(
  parameter int               LFSR_W = 7,
  parameter logic [LFSR_W-1:0] POLY  = DEF_POLY,
  parameter logic [LFSR_W-1:0] SEED  = DEF_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic adv_i,
  output logic k_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] cur_s;

  // Current LFSR value; a load substitutes SEED for this very bit
  always_comb begin
    if (load_i) begin
      cur_s = SEED;
    end else begin
      cur_s = lfsr_q;
    end
  end

  assign k_o = cur_s[LFSR_W-1];

  // Next LFSR state: step from the (possibly reseeded) current value
  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = LFSR_W'(lfsr_next(32'(cur_s), 32'(POLY)));
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/lfsr_descrambler_rx.sv
// lfsr_descrambler_rx
//   Receive-side descrambler: regenerates the LFSR keystream, recovers
//   x = z ^ k, deserializes LSB-first into DATA_W-bit words and presents them
//   on a registered valid/ready output.
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     in_valid/in_bit     - scrambled serial input, always accepted
//     in_sync             - with in_valid: this bit is bit 0 of a new frame
//     out_valid/out_data  - recovered word, held until out_ready
//     out_ready           - consumer accepts the word
//     overflow            - sticky: a completed word was dropped
//     parity_err          - sticky parity mismatch (0 unless parity enabled)
//   Build option: define LFSR_DESCRAMBLER_PARITY_EN to expect one scrambled
//   even-parity bit after every word.
module lfsr_descrambler_rx
  import lfsr_scrambler_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] POLY   = DEF_POLY,
  parameter logic [LFSR_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_sync,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              overflow,
  output logic              parity_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef LFSR_DESCRAMBLER_PARITY_EN
  // Slot DATA_W carries the parity bit
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic              parity_err_q, parity_err_d;

  logic              proc_s;
  logic              sync_s;
  logic              k_s;
  logic              d_s;
  logic              done_s;
  logic [CNT_W-1:0]  slot_s;
  logic [DATA_W-1:0] word_s;

  assign sync_s = in_valid & in_sync;
  // In IDLE only a sync bit is processed; in SHIFT every valid bit is
  assign proc_s = in_valid & (in_sync | (state_q == SHIFT));

  lfsr_keystream #(
    .LFSR_W (LFSR_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_keystream (
    .clk    (clk),
    .rst    (rst),
    .load_i (sync_s),
    .adv_i  (proc_s),
    .k_o    (k_s)
  );

  assign d_s = in_bit ^ k_s;

  // Bit position of the current bit and the word with that bit inserted;
  // a sync bit drops any partial word and lands at position 0
  always_comb begin
    slot_s = bit_cnt_q;
    word_s = shift_q;
    if (sync_s) begin
      slot_s = {CNT_W{1'b0}};
      word_s = {DATA_W{1'b0}};
    end else begin
      slot_s = bit_cnt_q;
      word_s = shift_q;
    end
    for (int i = 0; i < DATA_W; i++) begin
      if (slot_s == CNT_W'(i)) begin
        word_s[i] = d_s;
      end else begin
        word_s[i] = word_s[i];
      end
    end
  end

  assign done_s = proc_s & (slot_s == LAST_CNT);

  // Frame state, bit counter and deserializer
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (sync_s) begin
      state_d = SHIFT;
    end else begin
      state_d = state_q;
    end
    if (done_s) begin
      // Counter wraps; the LFSR keeps running into the next word
      bit_cnt_d = {CNT_W{1'b0}};
      shift_d   = {DATA_W{1'b0}};
    end else if (proc_s) begin
      bit_cnt_d = slot_s + CNT_ONE;
      shift_d   = word_s;
    end else begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
    end
  end

  // Output register, handshake and sticky flags
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    overflow_d   = overflow_q;
    parity_err_d = parity_err_q;
    if (done_s) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = word_s;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
`ifdef LFSR_DESCRAMBLER_PARITY_EN
    // On the parity slot word_s is the finished data word and d_s the
    // descrambled parity bit
    if (done_s && ((^word_s) != d_s)) begin
      parity_err_d = 1'b1;
    end else begin
      parity_err_d = parity_err_q;
    end
`else
    parity_err_d = 1'b0;
`endif
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= {CNT_W{1'b0}};
      shift_q      <= {DATA_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_lfsr_descrambler_rx.sv
// tb_lfsr_descrambler_rx
//   Self-checking bench for lfsr_descrambler_rx (DATA_W = 8, default LFSR).
//   Expected words are pushed to a queue as stimulus is driven and compared
//   when the consumer accepts a word. Honours LFSR_DESCRAMBLER_PARITY_EN.
module tb_lfsr_descrambler_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       in_sync;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       overflow;
  logic       parity_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_words = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [6:0] m_lfsr;

  always #5 clk = ~clk;

  lfsr_descrambler_rx dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_sync    (in_sync),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  // Scoreboard: a word visible with out_ready high is taken at the next edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_words++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got word %h, expected no word", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_data: got %h, expected %h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic drive(input logic b, input logic s);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_bit   = b;
    in_sync  = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_sync  = 1'b0;
    end
  endtask

  // Raw scrambled byte, LSB first, sync on bit 0
  task automatic send_raw(input logic [7:0] z);
    logic [7:0] zz;
    zz = z;
    for (int i = 0; i < 8; i++) drive(zz[i], (i == 0));
  endtask

  // Scramble with the bench's own x^7+x^6+1 model and send nbits data bits
  // (plus the parity bit for a full word when parity is built in)
  task automatic send_frame(input logic [7:0] x, input bit sync, input int nbits);
    logic k;
    for (int i = 0; i < nbits; i++) begin
      if (sync && i == 0) m_lfsr = 7'h7F;
      k      = m_lfsr[6];
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      drive(x[i] ^ k, sync && (i == 0));
    end
`ifdef LFSR_DESCRAMBLER_PARITY_EN
    if (nbits == 8) begin
      k      = m_lfsr[6];
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      drive((^x) ^ k, 1'b0);
    end
`endif
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_sync   = 1'b0;
    out_ready = 1'b1;
    m_lfsr    = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_tests += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", out_data); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", overflow); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_par: got %b, expected 0", parity_err); end
  endtask

  task automatic test_seed();
    exp_q.push_back(8'h00);
    send_raw(8'h7F);
`ifdef LFSR_DESCRAMBLER_PARITY_EN
    drive(1'b0, 1'b0);
`endif
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seed_early: got valid %b, expected 0", out_valid); end
    idle(1);
    @(negedge clk);
    n_tests += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seed_latency: got valid %b, expected 1", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL seed_data: got %h, expected 00", out_data); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL seed_ovf: got %b, expected 0", overflow); end
    idle(2);
  endtask

  task automatic test_data();
    exp_q.push_back(8'hA5);
    send_raw(8'hDA);
`ifdef LFSR_DESCRAMBLER_PARITY_EN
    drive(1'b0, 1'b0);
`endif
    idle(1);
    @(negedge clk);
    n_tests++;
    if (out_data !== 8'hA5) begin n_fail++; $display("FAIL data_A5: got %h, expected a5", out_data); end
    idle(2);
  endtask

  task automatic test_ignore();
    int w0;
    apply_reset();
    w0 = n_words;
    for (int i = 0; i < 5; i++) drive(1'($urandom_range(0, 1)), 1'b0);
    exp_q.push_back(8'h00);
    send_raw(8'h7F);
`ifdef LFSR_DESCRAMBLER_PARITY_EN
    drive(1'b0, 1'b0);
`endif
    idle(4);
    n_tests++;
    if (n_words - w0 != 1) begin n_fail++; $display("FAIL ignore_count: got %0d words, expected 1", n_words - w0); end
  endtask

  task automatic test_back_to_back();
    int         w0;
    logic [7:0] w[4];
    apply_reset();
    w0 = n_words;
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom_range(0, 255));
      exp_q.push_back(w[i]);
    end
    for (int i = 0; i < 4; i++) send_frame(w[i], (i == 0), 8);
    idle(4);
    n_tests++;
    if (n_words - w0 != 4) begin n_fail++; $display("FAIL b2b_count: got %0d words, expected 4", n_words - w0); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 8);
    send_frame(8'h96, 1'b0, 8);
    idle(2);
    @(negedge clk);
    n_tests += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, expected 1", out_valid); end
    if (out_data !== 8'h5A) begin n_fail++; $display("FAIL bp_hold: got %h, expected 5a", out_data); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b, expected 1", overflow); end
    exp_q.push_back(8'h5A);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got valid %b, expected 0", out_valid); end
  endtask

  task automatic test_resync();
    int w0;
    apply_reset();
    w0 = n_words;
    send_frame(8'hE7, 1'b1, 4);
    exp_q.push_back(8'h4B);
    send_frame(8'h4B, 1'b1, 8);
    idle(4);
    n_tests++;
    if (n_words - w0 != 1) begin n_fail++; $display("FAIL resync_count: got %0d words, expected 1", n_words - w0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    apply_reset();
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 8);
    send_frame(8'hC3, 1'b0, 8);
    send_frame(8'h11, 1'b0, 3);
    idle(1);
    @(negedge clk);
    n_tests += 2;
    if (out_data !== 8'h3C) begin n_fail++; $display("FAIL rstmid_pre_data: got %h, expected 3c", out_data); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_ovf: got %b, expected 1", overflow); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h, expected 00", out_data); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %b, expected 0", overflow); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_par: got %b, expected 0", parity_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    w0 = n_words;
    // Back in IDLE: unsynced bits must be ignored
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    exp_q.push_back(8'h00);
    send_raw(8'h7F);
`ifdef LFSR_DESCRAMBLER_PARITY_EN
    drive(1'b0, 1'b0);
`endif
    idle(4);
    n_tests++;
    if (n_words - w0 != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d words, expected 1", n_words - w0); end
  endtask

`ifdef LFSR_DESCRAMBLER_PARITY_EN
  task automatic test_parity();
    for (int f = 0; f < 2; f++) begin
      apply_reset();
      exp_q.push_back(8'hA5);
      send_raw(8'hDA);
      drive(f[0], 1'b0);
      idle(1);
      @(negedge clk);
      n_tests += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL par_valid%0d: got %b, expected 1", f, out_valid); end
      if (out_data !== 8'hA5) begin n_fail++; $display("FAIL par_data%0d: got %h, expected a5", f, out_data); end
      if (parity_err !== f[0]) begin n_fail++; $display("FAIL par_err%0d: got %b, expected %b", f, parity_err, f[0]); end
      idle(2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seed();
    test_data();
    test_ignore();
    test_back_to_back();
    test_backpressure();
    test_resync();
    test_reset_mid();
`ifdef LFSR_DESCRAMBLER_PARITY_EN
    test_parity();
`endif
    idle(3);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d undelivered words, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_descrambler_rx.md
Name: lfsr_descrambler_rx

Overview:
- Receive-side decoder for the team's XOR-scrambled serial bit stream.
- The transmitter sends z = x ^ k, where k is an LFSR keystream. This block regenerates k, recovers x = z ^ k, deserializes LSB-first into words, and presents them on a valid/ready output.
- Sits between the serial line interface and the word-level consumer.

Parameters:
- DATA_W, 8, bits per recovered word (2..32)
- LFSR_W, 7, LFSR length
- POLY, 7'h60, feedback tap mask (x^7+x^6+1)
- SEED, 7'h7F, LFSR load value at frame start; must be non-zero

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_bit is valid this cycle; always accepted, no backpressure
- in_bit  in  1  scrambled serial bit z
- in_sync  in  1  qualified by in_valid; marks this bit as bit 0 of a new frame
- out_valid  out  1  out_data holds an unread word
- out_data  out  DATA_W  recovered word, LSB = first received bit
- out_ready  in  1  consumer accepts the word when out_valid & out_ready
- overflow  out  1  sticky: a completed word was dropped
- parity_err  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE, lfsr = SEED, bit_cnt = 0, shift register = 0, out_valid = 0, out_data = 0, overflow = 0, parity_err = 0. Reset mid-word discards the partial word.
- States:
  - IDLE: in_valid bits without in_sync are ignored and the LFSR does not advance. in_valid & in_sync moves to SHIFT and processes that bit as bit 0.
  - SHIFT: every in_valid bit is processed.
- Keystream per processed bit:
  - k = lfsr[LFSR_W-1] before the update.
  - Update: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & POLY)}.
  - On an in_sync bit, the LFSR is treated as SEED for that bit, i.e. k = SEED[LFSR_W-1], then advances from SEED.
- Decoded bit d = in_bit ^ k is stored at position bit_cnt; bit_cnt increments.
- in_sync in SHIFT restarts the frame: partial word discarded, bit_cnt restarts at 0, LFSR reseeded. No overflow is flagged.
- Word completion: when bit DATA_W-1 is processed, the word goes to the output register and out_valid = 1 on the next cycle. Latency is 1 clock after the last bit. bit_cnt wraps to 0 and the LFSR keeps running; it is not reseeded per word.
- Output handshake:
  - out_data is stable while out_valid & !out_ready.
  - Acceptance clears out_valid the next cycle unless a new word completes in the same cycle.
  - Completion while out_valid & !out_ready: new word dropped, out_data unchanged, overflow <= 1 (sticky until rst).
  - Completion with out_valid & out_ready in the same cycle: new word loaded, out_valid stays 1, no overflow.
- in_valid = 0 cycles hold all state.
- Back-to-back in_valid every cycle is supported at full rate.

Optional Feature:
- Macro: LFSR_DESCRAMBLER_PARITY_EN
- Enabled:
  - Each word is followed by one extra scrambled bit. It is descrambled with the next k and consumes an LFSR step.
  - The bit is even parity over the DATA_W data bits.
  - The word is presented on that parity bit's cycle + 1.
  - A mismatch sets parity_err (sticky); the word is still delivered.
  - in_sync on the parity slot restarts the frame and the word is discarded.
- Disabled: no parity slot; parity_err tied 0.

Decomposition:
- Package lfsr_scrambler_pkg, shared with the transmitter:
  - constants DEF_POLY and DEF_SEED
  - a function computing the next LFSR state
  - state enum {IDLE, SHIFT}
- Sub-module lfsr_keystream (seed load, advance enable, k output), reused by the transmitter.

Test Plan:
- Seed check: in_sync with the bit stream of 0x7F sent LSB-first (1,1,1,1,1,1,1,0), in_valid every cycle, out_ready = 1 -> out_data = 0x00, out_valid one cycle after the 8th bit, overflow = 0.
- Data recovery: in_sync, then the bits of 0xDA sent LSB-first (0,1,0,1,1,0,1,1) -> out_data = 0xA5.
- Ignore before sync: 5 in_valid bits without in_sync, then the seed-check stream -> out_data = 0x00, exactly one word delivered.
- Backpressure: out_ready = 0, two full words streamed -> first word held, second dropped, overflow = 1; raise out_ready -> the first word is accepted and out_valid falls.
- Resync and reset: in_sync at bit 4 of a word -> no word emitted for the partial word, and the next 8 bits decode from SEED. Assert rst mid-word -> all outputs 0 immediately, state IDLE.
- Parity (macro defined): 0xA5 data then a correct parity bit -> parity_err = 0. Repeat with the parity bit flipped -> parity_err = 1 and out_data = 0xA5 still delivered.
